// File: rtl/vga_sink_mon.sv
`default_nettype none
// ============================================================================
// Module   : vga_sink_mon
// Function : VGA receive-side monitor. Recovers pixel coordinates, measures
//            line/frame timing, tracks lock and signs every frame's pixels.
// Revision : 1.0
// ============================================================================
module vga_sink_mon #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  input  logic [5:0]  rgb,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [5:0]  px_rgb,
  output logic        locked,
  output logic [9:0]  h_meas,
  output logic [9:0]  v_meas,
  output logic [15:0] frame_sig,
  output logic        sig_valid,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam logic       c_sync_pol = (SYNC_POL != 0);
  localparam logic [9:0] c_h_total  = 10'(H_TOTAL);
  localparam logic [9:0] c_v_total  = 10'(V_TOTAL);
  localparam logic [9:0] c_h_active = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_active = 10'(V_ACTIVE);
  localparam logic [9:0] c_cnt_max  = 10'h3FF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;

  logic        r_hs_prev, r_vs_prev, r_de_prev;
  logic [9:0]  r_x_cnt, r_y_cnt, r_hcnt, r_line_cnt, r_act_cnt;
  logic        r_have_line;
  logic [15:0] r_sig_acc;

  logic        w_hs_act, w_vs_act, w_hs_lead, w_vs_lead, w_de_fall;
  logic        w_checking, w_chk_h;
  logic [9:0]  w_h_per;
  logic        w_viol_h, w_viol_a, w_viol_v, w_viol;

  // Counters hold at their maximum so a lost sync cannot wrap into a match.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == c_cnt_max) ? v : v + 10'd1;
  endfunction

  assign w_hs_act  = (hsync == c_sync_pol);
  assign w_vs_act  = (vsync == c_sync_pol);
  assign w_hs_lead = w_hs_act & ~r_hs_prev;
  assign w_vs_lead = w_vs_act & ~r_vs_prev;
  assign w_de_fall = ~de & r_de_prev;

  assign w_checking = (r_state != ST_SEARCH);
  assign w_h_per    = sat_inc10(r_hcnt);
  assign w_chk_h    = w_checking & w_hs_lead & r_have_line;

  assign w_viol_h = w_chk_h & (w_h_per != c_h_total);
  assign w_viol_a = w_checking & w_de_fall & (r_act_cnt != c_h_active);
  assign w_viol_v = w_checking & w_vs_lead &
                    ((r_line_cnt != c_v_total) | (r_y_cnt != c_v_active));
  assign w_viol   = w_viol_h | w_viol_a | w_viol_v;

  assign locked = (r_state == ST_LOCKED);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SEARCH: if (w_vs_lead) w_state_nxt = ST_TRAIN;
      ST_TRAIN: begin
        if (w_viol)         w_state_nxt = ST_SEARCH;
        else if (w_vs_lead) w_state_nxt = ST_LOCKED;
      end
      ST_LOCKED: if (w_viol) w_state_nxt = ST_SEARCH;
      default:   w_state_nxt = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_SEARCH;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_prev   <= 1'b0;
      r_vs_prev   <= 1'b0;
      r_de_prev   <= 1'b0;
      r_x_cnt     <= '0;
      r_y_cnt     <= '0;
      r_hcnt      <= '0;
      r_line_cnt  <= '0;
      r_act_cnt   <= '0;
      r_have_line <= 1'b0;
      r_sig_acc   <= '0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
      h_meas      <= '0;
      v_meas      <= '0;
      frame_sig   <= '0;
      sig_valid   <= 1'b0;
      err         <= 1'b0;
      err_cnt     <= '0;
    end else begin
      r_hs_prev <= w_hs_act;
      r_vs_prev <= w_vs_act;
      r_de_prev <= de;

      px_valid <= de;
      px_rgb   <= rgb;
      px_x     <= w_hs_lead ? 10'd0 : r_x_cnt;
      px_y     <= r_y_cnt;

      if (w_hs_lead)  r_x_cnt <= de ? 10'd1 : 10'd0;
      else if (de)    r_x_cnt <= sat_inc10(r_x_cnt);

      if (w_hs_lead)  r_hcnt <= '0;
      else            r_hcnt <= sat_inc10(r_hcnt);

      if (w_vs_lead)      r_y_cnt <= '0;
      else if (w_de_fall) r_y_cnt <= sat_inc10(r_y_cnt);

      // A vsync lead that coincides with an hsync lead opens line 1 of the frame.
      if (w_vs_lead)      r_line_cnt <= {9'd0, w_hs_lead};
      else if (w_hs_lead) r_line_cnt <= sat_inc10(r_line_cnt);

      if (w_de_fall)  r_act_cnt <= '0;
      else if (de)    r_act_cnt <= sat_inc10(r_act_cnt);

      if (r_state == ST_SEARCH) r_have_line <= 1'b0;
      else if (w_hs_lead)       r_have_line <= 1'b1;

      if (w_chk_h)                 h_meas <= w_h_per;
      if (w_checking & w_vs_lead)  v_meas <= r_line_cnt;

      if (w_vs_lead) begin
        frame_sig <= r_sig_acc;
        r_sig_acc <= de ? {10'd0, rgb} : 16'd0;
      end else if (de) begin
        r_sig_acc <= {r_sig_acc[14:0], r_sig_acc[15]} ^ {10'd0, rgb};
      end

      sig_valid <= w_vs_lead & (r_state == ST_LOCKED) & ~w_viol;

      err <= w_viol;
      if (w_viol && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sink_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sink_mon
// Function : Directed bench for vga_sink_mon on a reduced 24x8 (16x4 active)
//            mode, with an active-low and an active-high sync instance.
// Revision : 1.0
// ============================================================================
module tb_vga_sink_mon;

  localparam int c_ht = 24, c_vt = 8, c_ha = 16, c_va = 4;

  logic clk, rst_n, hs_a, vs_a, de;
  logic [5:0] rgb;

  logic        px_valid0, px_valid1, locked0, locked1;
  logic [9:0]  px_x0, px_x1, px_y0, px_y1, h_meas0, h_meas1, v_meas0, v_meas1;
  logic [5:0]  px_rgb0, px_rgb1;
  logic [15:0] frame_sig0, frame_sig1;
  logic        sig_valid0, sig_valid1, err0, err1;
  logic [7:0]  err_cnt0, err_cnt1;
  logic [73:0] all_out0, all_out1;

  int n_cmp = 0, n_bad = 0;
  int n_err0 = 0, n_err1 = 0, n_sig0 = 0;

  int f_err_line, f_rst_bad, f_rst_samples;
  logic f_lock0, f_lock1, f_sigv0;
  logic [15:0] f_sig0, f_sig1;
  logic f_hot_valid;
  logic [9:0] f_hot_x, f_hot_y;
  logic [5:0] f_hot_rgb;

  vga_sink_mon #(.H_TOTAL(c_ht), .V_TOTAL(c_vt), .H_ACTIVE(c_ha), .V_ACTIVE(c_va), .SYNC_POL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .hsync(~hs_a), .vsync(~vs_a), .de(de), .rgb(rgb),
    .px_valid(px_valid0), .px_x(px_x0), .px_y(px_y0), .px_rgb(px_rgb0), .locked(locked0),
    .h_meas(h_meas0), .v_meas(v_meas0), .frame_sig(frame_sig0), .sig_valid(sig_valid0),
    .err(err0), .err_cnt(err_cnt0));

  vga_sink_mon #(.H_TOTAL(c_ht), .V_TOTAL(c_vt), .H_ACTIVE(c_ha), .V_ACTIVE(c_va), .SYNC_POL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hsync(hs_a), .vsync(vs_a), .de(de), .rgb(rgb),
    .px_valid(px_valid1), .px_x(px_x1), .px_y(px_y1), .px_rgb(px_rgb1), .locked(locked1),
    .h_meas(h_meas1), .v_meas(v_meas1), .frame_sig(frame_sig1), .sig_valid(sig_valid1),
    .err(err1), .err_cnt(err_cnt1));

  assign all_out0 = {px_valid0, px_x0, px_y0, px_rgb0, locked0, h_meas0, v_meas0,
                     frame_sig0, sig_valid0, err0, err_cnt0};
  assign all_out1 = {px_valid1, px_x1, px_y1, px_rgb1, locked1, h_meas1, v_meas1,
                     frame_sig1, sig_valid1, err1, err_cnt1};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err0) n_err0++;
    if (err1) n_err1++;
    if (sig_valid0) n_sig0++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: hsync active clocks 0-2, de clocks 4-19 on lines 2-5, vsync lines 0-1.
  // hot: 1 = rgb 3F at first active pixel, 2 = at last active pixel.
  task automatic run_frame(input int short_line, input int short_de_line, input int hot, input int rst_line);
    int hlen, dlen;
    logic hot_now;
    f_err_line = -1; f_rst_bad = 0; f_rst_samples = 0;
    for (int l = 0; l < c_vt; l++) begin
      hlen = (l == short_line) ? c_ht - 1 : c_ht;
      dlen = (l == short_de_line) ? c_ha - 1 : c_ha;
      for (int c = 0; c < hlen; c++) begin
        hs_a = (c < 3);
        vs_a = (l < 2);
        de   = (l >= 2 && l < 2 + c_va && c >= 4 && c < 4 + dlen);
        hot_now = de && ((hot == 1 && l == 2 && c == 4) || (hot == 2 && l == 5 && c == 19));
        rgb  = hot_now ? 6'h3F : 6'h00;
        if (l == rst_line && c == 11) rst_n = 1'b1;
        if (l == rst_line && c == 8) begin
          rst_n = 1'b0;
          #1;
          f_rst_samples++;
          if (all_out0 != '0 || all_out1 != '0) f_rst_bad++;
        end
        step();
        if (l == rst_line && c >= 8 && c < 11) begin
          f_rst_samples++;
          if (all_out0 != '0 || all_out1 != '0) f_rst_bad++;
        end
        if (l == 0 && c == 0) begin
          f_lock0 = locked0; f_lock1 = locked1; f_sigv0 = sig_valid0;
          f_sig0 = frame_sig0; f_sig1 = frame_sig1;
        end
        if (hot_now) begin
          f_hot_valid = px_valid0; f_hot_x = px_x0; f_hot_y = px_y0; f_hot_rgb = px_rgb0;
        end
        if (err0 && f_err_line < 0) f_err_line = l * 100 + c;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hs_a = 0; vs_a = 0; de = 0; rgb = 0;
    step(); step(); step();
    n_cmp++; if (all_out0 !== '0) begin n_bad++; $display("FAIL reset_out0: got %h exp 0", all_out0); end
    n_cmp++; if (all_out1 !== '0) begin n_bad++; $display("FAIL reset_out1: got %h exp 0", all_out1); end
    rst_n = 1'b1;
    step(); step();
  endtask

  task automatic test_lock();
    run_frame(-1, -1, 0, -1);
    n_cmp++; if (f_lock0 !== 1'b0) begin n_bad++; $display("FAIL lock_first_vs: got %b exp 0", f_lock0); end
    run_frame(-1, -1, 0, -1);
    n_cmp++; if (f_lock0 !== 1'b1) begin n_bad++; $display("FAIL lock_second_vs0: got %b exp 1", f_lock0); end
    n_cmp++; if (f_lock1 !== 1'b1) begin n_bad++; $display("FAIL lock_second_vs1: got %b exp 1", f_lock1); end
    n_cmp++; if (h_meas0 !== 10'd24) begin n_bad++; $display("FAIL h_meas0: got %0d exp 24", h_meas0); end
    n_cmp++; if (v_meas0 !== 10'd8) begin n_bad++; $display("FAIL v_meas0: got %0d exp 8", v_meas0); end
    n_cmp++; if (h_meas1 !== 10'd24) begin n_bad++; $display("FAIL h_meas1: got %0d exp 24", h_meas1); end
    n_cmp++; if (v_meas1 !== 10'd8) begin n_bad++; $display("FAIL v_meas1: got %0d exp 8", v_meas1); end
    run_frame(-1, -1, 0, -1);
    n_cmp++; if (f_sig0 !== 16'h0000) begin n_bad++; $display("FAIL sig_zero_frame: got %h exp 0000", f_sig0); end
    n_cmp++; if (n_err0 !== 0 || n_err1 !== 0) begin n_bad++; $display("FAIL lock_err_pulses: got %0d/%0d exp 0/0", n_err0, n_err1); end
    n_cmp++; if (err_cnt0 !== 8'd0 || err_cnt1 !== 8'd0) begin n_bad++; $display("FAIL lock_err_cnt: got %0d/%0d exp 0/0", err_cnt0, err_cnt1); end
    n_cmp++; if (locked0 !== 1'b1) begin n_bad++; $display("FAIL lock_hold: got %b exp 1", locked0); end
  endtask

  task automatic test_signature();
    int sig_base;
    run_frame(-1, -1, 1, -1);
    n_cmp++; if (f_hot_valid !== 1'b1 || f_hot_rgb !== 6'h3F) begin n_bad++; $display("FAIL first_px_data: got %b/%h exp 1/3f", f_hot_valid, f_hot_rgb); end
    n_cmp++; if (f_hot_x !== 10'd0 || f_hot_y !== 10'd0) begin n_bad++; $display("FAIL first_px_xy: got %0d/%0d exp 0/0", f_hot_x, f_hot_y); end
    sig_base = n_sig0;
    run_frame(-1, -1, 0, -1);
    // 64 de cycles: 3F then 63 rotations -> rotate-left by 15
    n_cmp++; if (f_sig0 !== 16'h801F) begin n_bad++; $display("FAIL sig_first_px0: got %h exp 801f", f_sig0); end
    n_cmp++; if (f_sig1 !== 16'h801F) begin n_bad++; $display("FAIL sig_first_px1: got %h exp 801f", f_sig1); end
    n_cmp++; if (f_sigv0 !== 1'b1) begin n_bad++; $display("FAIL sig_valid_at_vs: got %b exp 1", f_sigv0); end
    n_cmp++; if (n_sig0 - sig_base !== 1) begin n_bad++; $display("FAIL sig_valid_pulses: got %0d exp 1", n_sig0 - sig_base); end
    run_frame(-1, -1, 2, -1);
    n_cmp++; if (f_hot_x !== 10'd15 || f_hot_y !== 10'd3) begin n_bad++; $display("FAIL last_px_xy: got %0d/%0d exp 15/3", f_hot_x, f_hot_y); end
    run_frame(-1, -1, 0, -1);
    n_cmp++; if (f_sig0 !== 16'h003F) begin n_bad++; $display("FAIL sig_last_px: got %h exp 003f", f_sig0); end
  endtask

  task automatic test_short_line();
    int err_base;
    err_base = n_err0;
    run_frame(6, -1, 0, -1);
    n_cmp++; if (f_err_line !== 700) begin n_bad++; $display("FAIL short_line_err_pos: got %0d exp 700", f_err_line); end
    n_cmp++; if (err_cnt0 !== 8'd1 || err_cnt1 !== 8'd1) begin n_bad++; $display("FAIL short_line_err_cnt: got %0d/%0d exp 1/1", err_cnt0, err_cnt1); end
    n_cmp++; if (locked0 !== 1'b0) begin n_bad++; $display("FAIL short_line_unlock: got %b exp 0", locked0); end
    n_cmp++; if (h_meas0 !== 10'd23) begin n_bad++; $display("FAIL short_line_h_meas: got %0d exp 23", h_meas0); end
    n_cmp++; if (n_err0 - err_base !== 1) begin n_bad++; $display("FAIL short_line_pulses: got %0d exp 1", n_err0 - err_base); end
    run_frame(-1, -1, 0, -1);
    n_cmp++; if (f_lock0 !== 1'b0) begin n_bad++; $display("FAIL relock_train: got %b exp 0", f_lock0); end
    run_frame(-1, -1, 0, -1);
    n_cmp++; if (f_lock0 !== 1'b1) begin n_bad++; $display("FAIL relock_locked: got %b exp 1", f_lock0); end
  endtask

  task automatic test_short_de();
    int err_base;
    err_base = n_err0;
    run_frame(-1, 3, 0, -1);
    n_cmp++; if (f_err_line !== 319) begin n_bad++; $display("FAIL short_de_err_pos: got %0d exp 319", f_err_line); end
    n_cmp++; if (err_cnt0 !== 8'd2) begin n_bad++; $display("FAIL short_de_err_cnt: got %0d exp 2", err_cnt0); end
    n_cmp++; if (n_err0 - err_base !== 1) begin n_bad++; $display("FAIL short_de_pulses: got %0d exp 1", n_err0 - err_base); end
    n_cmp++; if (locked0 !== 1'b0) begin n_bad++; $display("FAIL short_de_unlock: got %b exp 0", locked0); end
    run_frame(-1, -1, 0, -1);
    run_frame(-1, -1, 0, -1);
    n_cmp++; if (f_lock0 !== 1'b1) begin n_bad++; $display("FAIL short_de_relock: got %b exp 1", f_lock0); end
  endtask

  task automatic test_async_reset();
    run_frame(-1, -1, 0, 3);
    n_cmp++; if (f_rst_samples !== 4 || f_rst_bad !== 0) begin n_bad++; $display("FAIL reset_mid_outputs: got %0d nonzero of %0d exp 0 of 4", f_rst_bad, f_rst_samples); end
    n_cmp++; if (err_cnt0 !== 8'd0 || locked0 !== 1'b0) begin n_bad++; $display("FAIL reset_mid_state: got cnt %0d lock %b exp 0/0", err_cnt0, locked0); end
    run_frame(-1, -1, 0, -1);
    n_cmp++; if (f_lock0 !== 1'b0) begin n_bad++; $display("FAIL reset_relock_first: got %b exp 0", f_lock0); end
    run_frame(-1, -1, 0, -1);
    n_cmp++; if (f_lock0 !== 1'b1 || f_lock1 !== 1'b1) begin n_bad++; $display("FAIL reset_relock_second: got %b/%b exp 1/1", f_lock0, f_lock1); end
  endtask

  task automatic test_saturation();
    int err_base;
    err_base = n_err0;
    hs_a = 0; rgb = 0;
    for (int i = 0; i < 300; i++) begin
      vs_a = 1; de = 0; step();
      vs_a = 0; de = 1; step();
      de = 0; step();
      if (i == 254) begin
        n_cmp++; if (err_cnt0 !== 8'd255) begin n_bad++; $display("FAIL sat_reach0: got %0d exp 255", err_cnt0); end
      end
    end
    step();
    n_cmp++; if (err_cnt0 !== 8'd255 || err_cnt1 !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d/%0d exp 255/255", err_cnt0, err_cnt1); end
    n_cmp++; if (n_err0 - err_base !== 300) begin n_bad++; $display("FAIL sat_pulses: got %0d exp 300", n_err0 - err_base); end
  endtask

  initial begin
    clk = 1'b0;
    test_reset();
    test_lock();
    test_signature();
    test_short_line();
    test_short_de();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
